iob_clint_cmp_ctrl: RTL and testbench

IOB_CLINT_CMP_CTRL -- requirements
Module: iob_clint_cmp_ctrl

---
 rtl/iob_clint_cmp_ctrl.sv | 175 +++++++++++++++++
 tb/tb_iob_clint_cmp_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_clint_cmp_ctrl.sv
// iob_clint_cmp_ctrl
// Arbitrates per-hart mtimecmp update requests round-robin and turns the
// granted 64-bit compare value into 32-bit bus writes towards the timer.
// Optional macro IOB_CLINT_CMP_CTRL_SAFE_SEQ_EN: first parks the high word at
// all ones so the compare cannot match spuriously while the low word changes.
// Without it only the low and high words are written.
module iob_clint_cmp_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                N_CORES  = 1,
    parameter logic [ADDR_W-1:0] CMP_BASE = ADDR_W'(16'h4000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CORES-1:0]    req_valid,
    input  logic [64*N_CORES-1:0] req_cmp,
    output logic [N_CORES-1:0]    req_ack,
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int GW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_HMAX,
        GAP,
        WR_LO,
        WR_HI,
        ACK
    } state_t;

    state_t              state, state_n;
    state_t              gap_next, gap_next_n;
    logic [GW-1:0]       grant, grant_n;
    logic [63:0]         cmp_lat, cmp_n;
    logic                found;
    int                  rr_idx;
    logic                hs;

    logic                m_valid_n;
    logic [ADDR_W-1:0]   m_address_n;
    logic [DATA_W-1:0]   m_wdata_n;
    logic [DATA_W/8-1:0] m_wstrb_n;
    logic [N_CORES-1:0]  req_ack_n;
    logic [ADDR_W-1:0]   slot_addr;

    assign hs   = m_valid && m_ready;
    assign busy = (state != IDLE);

    // Next-state logic: round-robin grant in IDLE, then walk the write sequence.
    // The grant register doubles as the round-robin pointer.
    always_comb begin
        state_n    = state;
        gap_next_n = gap_next;
        grant_n    = grant;
        cmp_n      = cmp_lat;
        found      = 1'b0;
        rr_idx     = 0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= N_CORES; k++) begin
                    rr_idx = int'(grant) + k;
                    if (rr_idx >= N_CORES) begin
                        rr_idx = rr_idx - N_CORES;
                    end
                    if (!found && req_valid[rr_idx]) begin
                        found   = 1'b1;
                        grant_n = GW'(rr_idx);
                    end
                end
                if (found) begin
                    cmp_n = req_cmp[int'(grant_n)*64 +: 64];
`ifdef IOB_CLINT_CMP_CTRL_SAFE_SEQ_EN
                    state_n = WR_HMAX;
`else
                    state_n = WR_LO;
`endif
                end
            end
            WR_HMAX: begin
                if (hs) begin
                    state_n    = GAP;
                    gap_next_n = WR_LO;
                end
            end
            WR_LO: begin
                if (hs) begin
                    state_n    = GAP;
                    gap_next_n = WR_HI;
                end
            end
            GAP: begin
                state_n = gap_next;
            end
            WR_HI: begin
                if (hs) begin
                    state_n = ACK;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bus and ack values for the state being entered, so every output is a register.
    always_comb begin
        m_valid_n   = 1'b0;
        m_address_n = '0;
        m_wdata_n   = '0;
        m_wstrb_n   = '0;
        req_ack_n   = '0;
        slot_addr   = CMP_BASE + (ADDR_W'(grant_n) << 3);
        case (state_n)
            WR_HMAX: begin
                m_valid_n   = 1'b1;
                m_address_n = slot_addr + ADDR_W'(4);
                m_wdata_n   = DATA_W'(32'hFFFF_FFFF);
                m_wstrb_n   = '1;
            end
            WR_LO: begin
                m_valid_n   = 1'b1;
                m_address_n = slot_addr;
                m_wdata_n   = DATA_W'(cmp_n[31:0]);
                m_wstrb_n   = '1;
            end
            WR_HI: begin
                m_valid_n   = 1'b1;
                m_address_n = slot_addr + ADDR_W'(4);
                m_wdata_n   = DATA_W'(cmp_n[63:32]);
                m_wstrb_n   = '1;
            end
            ACK: begin
                req_ack_n = N_CORES'(1) << grant_n;
            end
            default: begin
                m_valid_n = 1'b0;
            end
        endcase
    end

    // State, grant pointer, latched compare value and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap_next  <= WR_LO;
            grant     <= GW'(N_CORES - 1);
            cmp_lat   <= '0;
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            req_ack   <= '0;
        end else begin
            state     <= state_n;
            gap_next  <= gap_next_n;
            grant     <= grant_n;
            cmp_lat   <= cmp_n;
            m_valid   <= m_valid_n;
            m_address <= m_address_n;
            m_wdata   <= m_wdata_n;
            m_wstrb   <= m_wstrb_n;
            req_ack   <= req_ack_n;
        end
    end

endmodule

// File: tb/tb_iob_clint_cmp_ctrl.sv
// Directed bench for iob_clint_cmp_ctrl with four requesters and a bus slave
// whose m_ready is a (optionally delayed) registered copy of m_valid.
// Expectations follow IOB_CLINT_CMP_CTRL_SAFE_SEQ_EN when it is defined.
module tb_iob_clint_cmp_ctrl;

    localparam int NC = 4;

`ifdef IOB_CLINT_CMP_CTRL_SAFE_SEQ_EN
    localparam int NB       = 3;
    localparam int ACK_LAT  = 9;
    localparam int ACK_SLOW = 18;
    localparam int LO_RISE  = 4;
`else
    localparam int NB       = 2;
    localparam int ACK_LAT  = 6;
    localparam int ACK_SLOW = 12;
    localparam int LO_RISE  = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req_valid;
    logic [64*NC-1:0]  req_cmp;
    logic [NC-1:0]     req_ack;
    logic              m_valid;
    logic [15:0]       m_address;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_ready;
    logic              busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int extra_delay = 0;
    int scnt;

    logic [15:0] beat_addr[$];
    logic [31:0] beat_data[$];
    logic [3:0]  beat_strb[$];
    int          rise_cyc[$];
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;
    int          zero_viol  = 0;
    int          stable_viol = 0;

    iob_clint_cmp_ctrl #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .N_CORES (NC),
        .CMP_BASE(16'h4000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_cmp  (req_cmp),
        .req_ack  (req_ack),
        .m_valid  (m_valid),
        .m_address(m_address),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure latencies.
    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: m_ready follows m_valid after extra_delay additional cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b0;
            scnt    <= 0;
        end else if (!m_valid) begin
            m_ready <= 1'b0;
            scnt    <= 0;
        end else begin
            m_ready <= (scnt >= extra_delay);
            scnt    <= scnt + 1;
        end
    end

    // Bus monitor: logs beats and m_valid rises, counts idle-zero and hold violations.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            beat_addr.push_back(m_address);
            beat_data.push_back(m_wdata);
            beat_strb.push_back(m_wstrb);
        end
        if (m_valid && !prev_valid) rise_cyc.push_back(cyc);
        if (!m_valid && (m_address != 0 || m_wdata != 0 || m_wstrb != 0))
            zero_viol <= zero_viol + 1;
        if (m_valid && prev_valid && !prev_ready &&
            (m_address != prev_addr || m_wdata != prev_data))
            stable_viol <= stable_viol + 1;
        prev_valid <= m_valid;
        prev_ready <= m_ready;
        prev_addr  <= m_address;
        prev_data  <= m_wdata;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int core, input logic [63:0] value);
        req_cmp[64*core +: 64] = value;
        req_valid[core]        = 1'b1;
    endtask

    task automatic clearLogs();
        beat_addr.delete();
        beat_data.delete();
        beat_strb.delete();
        rise_cyc.delete();
    endtask

    task automatic waitAck(input string tag, input int budget,
                           output logic [NC-1:0] vec, output int when);
        vec  = '0;
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ack != 0) begin
                vec  = req_ack;
                when = cyc;
                break;
            end
        end
        checkOutput({tag, "_ack_seen"}, 64'(when >= 0), 64'd1);
    endtask

    initial begin
        logic [NC-1:0] vec;
        int            when;
        int            c0;
        int            b;
        logic [NC-1:0] acks[5];
        logic [NC-1:0] exp_order[5];

        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst       = 1'b1;
        req_valid = '0;
        req_cmp   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_m_valid",   m_valid,   0);
        checkOutput("rst_m_address", m_address, 0);
        checkOutput("rst_m_wdata",   m_wdata,   0);
        checkOutput("rst_m_wstrb",   m_wstrb,   0);
        checkOutput("rst_req_ack",   req_ack,   0);
        checkOutput("rst_busy",      busy,      0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from core 0
        $display("[TB] single request, core 0");
        clearLogs();
        c0 = cyc;
        applyStimulus(0, 64'h0000_0001_0000_0010);
        waitAck("a", 40, vec, when);
        req_valid = '0;
        checkOutput("a_ack_cycle", when - c0, ACK_LAT);
        checkOutput("a_ack_vec", vec, 4'b0001);
        checkOutput("a_busy_in_ack", busy, 1);
        repeat (3) @(negedge clk);
        checkOutput("a_busy_idle", busy, 0);
        checkOutput("a_ack_clear", req_ack, 0);
        checkOutput("a_beats", beat_addr.size(), NB);
        if (beat_addr.size() == NB && rise_cyc.size() == NB) begin
`ifdef IOB_CLINT_CMP_CTRL_SAFE_SEQ_EN
            checkOutput("a_hmax_addr", beat_addr[0], 16'h4004);
            checkOutput("a_hmax_data", beat_data[0], 32'hFFFF_FFFF);
            checkOutput("a_rise2", rise_cyc[2] - c0, 7);
`endif
            checkOutput("a_strb", beat_strb[0], 4'hF);
            checkOutput("a_lo_addr", beat_addr[NB-2], 16'h4000);
            checkOutput("a_lo_data", beat_data[NB-2], 32'h0000_0010);
            checkOutput("a_hi_addr", beat_addr[NB-1], 16'h4004);
            checkOutput("a_hi_data", beat_data[NB-1], 32'h0000_0001);
            checkOutput("a_rise0", rise_cyc[0] - c0, 1);
            checkOutput("a_rise1", rise_cyc[1] - c0, 4);
        end

        // Round robin with all four cores requesting
        $display("[TB] round robin, all cores");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clearLogs();
        for (int k = 0; k < NC; k++)
            applyStimulus(k, {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)});
        for (int s = 0; s < 5; s++) begin
            waitAck($sformatf("b%0d", s), 40, vec, when);
            acks[s] = vec;
            if (s == 4) req_valid = '0;
        end
        for (int s = 0; s < 5; s++)
            checkOutput($sformatf("b_grant%0d", s), acks[s], exp_order[s]);
        repeat (3) @(negedge clk);
        checkOutput("b_beats", beat_addr.size(), 5 * NB);
        if (beat_addr.size() == 5 * NB) begin
            b = 2 * NB + NB - 2;
            checkOutput("b_core2_lo_addr", beat_addr[b],     16'h4010);
            checkOutput("b_core2_lo_data", beat_data[b],     32'hB000_0002);
            checkOutput("b_core2_hi_addr", beat_addr[b + 1], 16'h4014);
            checkOutput("b_core2_hi_data", beat_data[b + 1], 32'hA000_0002);
            checkOutput("b_core3_lo_addr", beat_addr[b + NB], 16'h4018);
        end

        // Slow slave and compare value changed after grant
        $display("[TB] delayed ready, late req_cmp change");
        extra_delay = 3;
        clearLogs();
        c0 = cyc;
        applyStimulus(1, 64'hDEAD_BEEF_1234_5678);
        repeat (2) @(negedge clk);
        req_cmp[64 +: 64] = 64'h1111_2222_3333_4444;
        waitAck("c", 60, vec, when);
        req_valid = '0;
        checkOutput("c_ack_cycle", when - c0, ACK_SLOW);
        checkOutput("c_ack_vec", vec, 4'b0010);
        repeat (3) @(negedge clk);
        extra_delay = 0;
        checkOutput("c_beats", beat_addr.size(), NB);
        if (beat_addr.size() == NB) begin
            checkOutput("c_lo_addr", beat_addr[NB-2], 16'h4008);
            checkOutput("c_lo_data", beat_data[NB-2], 32'h1234_5678);
            checkOutput("c_hi_addr", beat_addr[NB-1], 16'h400C);
            checkOutput("c_hi_data", beat_data[NB-1], 32'hDEAD_BEEF);
        end

        // Reset in the middle of the low-word write
        $display("[TB] reset during low-word write");
        clearLogs();
        applyStimulus(2, 64'h0000_0007_0000_0003);
        repeat (LO_RISE) @(negedge clk);
        checkOutput("d_in_lo_valid", m_valid, 1);
        checkOutput("d_in_lo_addr", m_address, 16'h4010);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("d_rst_m_valid", m_valid, 0);
        checkOutput("d_rst_busy", busy, 0);
        checkOutput("d_rst_req_ack", req_ack, 0);
        rst = 1'b0;
        clearLogs();
        c0 = cyc;
        applyStimulus(0, 64'h0000_0000_0000_0005);
        waitAck("d0", 40, vec, when);
        req_valid[0] = 1'b0;
        checkOutput("d_first_ack_vec", vec, 4'b0001);
        checkOutput("d_first_ack_cycle", when - c0, ACK_LAT);
        waitAck("d2", 40, vec, when);
        req_valid = '0;
        checkOutput("d_second_ack_vec", vec, 4'b0100);
        repeat (3) @(negedge clk);
        checkOutput("d_beats", beat_addr.size(), 2 * NB);
        if (beat_addr.size() == 2 * NB) begin
            checkOutput("d_lo_addr", beat_addr[NB-2], 16'h4000);
            checkOutput("d_lo_data", beat_data[NB-2], 32'h0000_0005);
            checkOutput("d_hi_addr", beat_addr[NB-1], 16'h4004);
            checkOutput("d_hi_data", beat_data[NB-1], 32'h0000_0000);
        end

        checkOutput("zero_when_idle", zero_viol, 0);
        checkOutput("stable_while_waiting", stable_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
